// File: rtl/program_loader.sv
// program_loader: assembles an MSB-first byte stream into instruction-memory writes and gates the core reset.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the end marker.
module program_loader #(
   parameter int WORD_W = 32,
   parameter int ADDR_W = 32,
   parameter int DEPTH_WORDS = 256,
   localparam int BPW = WORD_W / 8,
   localparam int CW = $clog2(DEPTH_WORDS) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              inst_mem_wr_en,
   output logic [ADDR_W-1:0] inst_mem_addr,
   output logic [WORD_W-1:0] inst_mem_data,
   output logic              cpu_reset,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [CW-1:0]     word_count
);
   localparam int BW = $clog2(BPW + 1);
   localparam logic [BW-1:0] LAST = BW'(BPW - 1);
`ifdef LOADER_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE, LOAD, CHECK, END} state_t;
   localparam state_t MARK_NEXT = CHECK;
`else
   typedef enum logic [1:0] {IDLE, LOAD, END} state_t;
   localparam state_t MARK_NEXT = END;
`endif
   state_t state, state_n;
   logic [WORD_W-1:0] word_buf, word_n;
   logic [BW-1:0] byte_cnt;
   logic [CW-1:0] count_eff;
   logic load_go, take, complete, marker, full, write;
   assign load_go = start && (state == IDLE || state == END);
   assign take = in_valid && state == LOAD;
   assign word_n = (word_buf << 8) | WORD_W'(in_data);
   assign complete = take && byte_cnt == LAST;
   assign marker = &word_n;
   // a write still in flight already owns its slot
   assign count_eff = word_count + CW'(inst_mem_wr_en);
   assign full = count_eff == CW'(DEPTH_WORDS);
   assign write = complete && !marker && !full;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0] checksum;
   function automatic logic [7:0] fold(input logic [WORD_W-1:0] w);
      fold = '0;
      for (int i = 0; i < BPW; i++) fold ^= w[8*i +: 8];
   endfunction
   assign busy = state == LOAD || state == CHECK;
`else
   assign busy = state == LOAD;
`endif
   assign in_ready = busy;
   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else state <= state_n;
   end
   always_comb begin
      state_n = state;
      if (load_go) state_n = LOAD;
      if (complete) state_n = marker ? MARK_NEXT : full ? END : LOAD;
`ifdef LOADER_CHECKSUM_EN
      if (state == CHECK && in_valid) state_n = END;
`endif
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         word_buf <= '0;
         byte_cnt <= '0;
         word_count <= '0;
         inst_mem_wr_en <= 1'b0;
         inst_mem_addr <= '0;
         inst_mem_data <= '0;
         cpu_reset <= 1'b1;
         done <= 1'b0;
         error <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         checksum <= '0;
`endif
      end else begin
         inst_mem_wr_en <= write;
         word_count <= count_eff;
         if (take) begin
            word_buf <= word_n;
            byte_cnt <= complete ? '0 : byte_cnt + 1'b1;
         end
         if (write) begin
            inst_mem_addr <= ADDR_W'(count_eff * BPW);
            inst_mem_data <= word_n;
         end
         if (complete && !marker && full) error <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
         if (write) checksum <= checksum ^ fold(word_n);
         if (state == CHECK && in_valid) begin
            done <= in_data == checksum;
            error <= in_data != checksum;
            cpu_reset <= in_data != checksum;
         end
         if (load_go) checksum <= '0;
`else
         if (complete && marker) begin
            done <= 1'b1;
            cpu_reset <= 1'b0;
         end
`endif
         if (load_go) begin
            word_buf <= '0;
            byte_cnt <= '0;
            word_count <= '0;
            done <= 1'b0;
            error <= 1'b0;
            cpu_reset <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed streams against a queue-based loader model plus literal end-of-load checks.
module tb_program_loader;
   localparam int DEPTH = 4;
   localparam int BPW = 4;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int P_IDLE = 0, P_LOAD = 1, P_CHECK = 2, P_END = 3;
   logic clk = 0;
   logic reset, start, in_valid;
   logic [7:0] in_data;
   logic in_ready, inst_mem_wr_en, cpu_reset, busy, done, error;
   logic [31:0] inst_mem_addr, inst_mem_data;
   logic [CW-1:0] word_count;
   program_loader #(.WORD_W(32), .ADDR_W(32), .DEPTH_WORDS(DEPTH)) dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .inst_mem_wr_en(inst_mem_wr_en), .inst_mem_addr(inst_mem_addr),
      .inst_mem_data(inst_mem_data), .cpu_reset(cpu_reset), .busy(busy), .done(done),
      .error(error), .word_count(word_count)
   );
   always #5 clk = ~clk;
   int total = 0, bad = 0;
   logic chk_on = 0;
   logic [31:0] words [5] = '{32'h3C0B00F0, 32'h01604009, 32'h3C08FFFF, 32'h21290004, 32'h11223344};
   logic [63:0] wlog [$];
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask
   logic s_reset = 0, s_start = 0, s_valid = 0;
   logic [7:0] s_data = 0;
   always @(posedge clk) begin
      s_reset <= reset;
      s_start <= start;
      s_valid <= in_valid;
      s_data <= in_data;
   end
   int m_phase, m_count, m_addr, old;
   logic m_wr, m_done, m_err, m_cpu;
   logic [31:0] m_data, w;
   logic [7:0] m_sum;
   logic [7:0] q [$];
   always @(negedge clk) begin
      if (!s_reset) begin
         m_phase = P_IDLE; q.delete(); m_count = 0; m_wr = 0; m_addr = 0; m_data = 0;
         m_done = 0; m_err = 0; m_cpu = 1; m_sum = 0;
      end else begin
         old = m_phase;
         if (m_wr) m_count++;
         m_wr = 0;
         if (s_valid && old == P_LOAD) begin
            q.push_back(s_data);
            if (q.size() == BPW) begin
               w = 0;
               foreach (q[i]) w = (w << 8) | 32'(q[i]);
               q.delete();
               if (w == 32'hFFFFFFFF) begin
`ifdef LOADER_CHECKSUM_EN
                  m_phase = P_CHECK;
`else
                  m_phase = P_END; m_done = 1; m_cpu = 0;
`endif
               end else if (m_count == DEPTH) begin
                  m_phase = P_END; m_err = 1;
               end else begin
                  m_wr = 1; m_addr = m_count * BPW; m_data = w;
                  m_sum = m_sum ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
               end
            end
         end else if (s_valid && old == P_CHECK) begin
            m_phase = P_END;
            if (s_data == m_sum) begin m_done = 1; m_cpu = 0; end
            else m_err = 1;
         end
         if (s_start && (old == P_IDLE || old == P_END)) begin
            m_phase = P_LOAD; m_count = 0; q.delete(); m_sum = 0; m_done = 0; m_err = 0; m_cpu = 1;
         end
      end
      if (chk_on) begin
         chk("in_ready", in_ready, m_phase == P_LOAD || m_phase == P_CHECK);
         chk("busy", busy, m_phase == P_LOAD || m_phase == P_CHECK);
         chk("done", done, m_done);
         chk("error", error, m_err);
         chk("cpu_reset", cpu_reset, m_cpu);
         chk("wr_en", inst_mem_wr_en, m_wr);
         chk("word_count", word_count, m_count);
         if (m_wr) begin
            chk("addr", inst_mem_addr, m_addr);
            chk("data", inst_mem_data, m_data);
         end
      end
      if (inst_mem_wr_en) wlog.push_back({inst_mem_addr, inst_mem_data});
   end
   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      in_valid = 0;
      repeat (gap) @(negedge clk);
      in_valid = 1;
      in_data = b;
      for (n = 0; n < 50 && !in_ready; n++) @(negedge clk);
      if (!in_ready) chk("ready_timeout", 0, 1);
      @(negedge clk);
      in_valid = 0;
   endtask
   task automatic send_word(input logic [31:0] v, input int maxgap);
      for (int i = 3; i >= 0; i--) send_byte(v[8*i +: 8], $urandom_range(0, maxgap));
   endtask
   task automatic pulse_start();
      start = 1;
      @(negedge clk);
      start = 0;
   endtask
   task automatic finish_stream(input int maxgap, input logic [7:0] sum);
      send_word(32'hFFFFFFFF, maxgap);
`ifdef LOADER_CHECKSUM_EN
      send_byte(sum, $urandom_range(0, maxgap));
`else
      if (sum == 8'h00) chk("sum_arg", 0, 1);
`endif
      repeat (3) @(negedge clk);
   endtask
   task automatic check_writes(input int n);
      chk("nwrites", wlog.size(), n);
      for (int i = 0; i < n && i < wlog.size(); i++)
         chk($sformatf("write%0d", i), wlog[i], {32'(i * 4), words[i]});
   endtask
   task automatic check_done();
      check_writes(4);
      chk("end_done", done, 1);
      chk("end_error", error, 0);
      chk("end_cpu_reset", cpu_reset, 0);
      chk("end_word_count", word_count, 4);
      chk("end_busy", busy, 0);
   endtask
   initial begin
      reset = 0; start = 0; in_valid = 0; in_data = 0;
      repeat (3) @(negedge clk);
      chk_on = 1;
      chk("rst_cpu_reset", cpu_reset, 1);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_wr_en", inst_mem_wr_en, 0);
      chk("rst_addr", inst_mem_addr, 0);
      chk("rst_data", inst_mem_data, 0);
      chk("rst_word_count", word_count, 0);
      reset = 1;
      @(negedge clk);
      pulse_start();
      chk("load_cpu_reset", cpu_reset, 1);
      chk("load_busy", busy, 1);
      for (int i = 0; i < 4; i++) send_word(words[i], 0);
      finish_stream(0, 8'hD7);
      check_done();
      wlog.delete();
      pulse_start();
      chk("restart_done_cleared", done, 0);
      chk("restart_count", word_count, 0);
      send_word(words[0], 3);
      send_word(words[1], 3);
      send_byte(8'h3C, 2);
      send_byte(8'h08, 1);
      pulse_start();
      chk("midload_busy", busy, 1);
      chk("midload_count", word_count, 2);
      send_byte(8'hFF, 3);
      send_byte(8'hFF, 0);
      send_word(words[3], 3);
      finish_stream(3, 8'hD7);
      check_done();
      wlog.delete();
      pulse_start();
      for (int i = 0; i < 5; i++) send_word(words[i], 1);
      repeat (3) @(negedge clk);
      check_writes(4);
      chk("ovf_error", error, 1);
      chk("ovf_done", done, 0);
      chk("ovf_cpu_reset", cpu_reset, 1);
      chk("ovf_busy", busy, 0);
      wlog.delete();
      pulse_start();
      send_word(words[0], 0);
      send_byte(8'h01, 0);
      send_byte(8'h60, 0);
      reset = 0;
      repeat (2) @(negedge clk);
      reset = 1;
      repeat (2) @(negedge clk);
      chk("rstmid_nwrites", wlog.size(), 1);
      chk("rstmid_busy", busy, 0);
      chk("rstmid_cpu_reset", cpu_reset, 1);
      chk("rstmid_count", word_count, 0);
      wlog.delete();
      pulse_start();
      for (int i = 0; i < 4; i++) send_word(words[i], 2);
      finish_stream(2, 8'hD7);
      check_done();
`ifdef LOADER_CHECKSUM_EN
      wlog.delete();
      pulse_start();
      for (int i = 0; i < 4; i++) send_word(words[i], 0);
      finish_stream(0, 8'hD6);
      chk("csum_bad_error", error, 1);
      chk("csum_bad_done", done, 0);
      chk("csum_bad_cpu_reset", cpu_reset, 1);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
